// File: rtl/nano_cpu_pkg.sv
// Shared nano-cpu definitions: fetch FSM states,
// instruction geometry and RV32 opcode/funct3 codes.
package nano_cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int LANE_W      = 2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: four byte reads per RV32 word, valid/ready out,
// redirect with in-flight discard, sticky misaligned-redirect fault.
// Ports: clk, rst_n | mem_req, mem_addr, mem_rdata |
//        instr_valid, instr_ready, instr, instr_pc |
//        redirect_valid, redirect_pc | fetch_fault
module instr_fetch_unit
  import nano_cpu_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_fault
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [31:0]       r_pc;
  logic [LANE_W-1:0] r_lane;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LANE_W-1:0] r_req_lane;
  logic              r_rsp_pend;
  logic [LANE_W-1:0] r_rsp_lane;
  logic [7:0]        r_buf [INSTR_BYTES-1];
  logic              r_instr_valid;
  logic [31:0]       r_instr;
  logic [31:0]       r_instr_pc;
  logic              r_fault;

  logic              w_hs;
  logic              w_aligned;
  logic              w_last;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [LANE_W-1:0] w_issue_lane;
  logic [31:0]       w_pc_inc;

  localparam logic [LANE_W-1:0] LAST_LANE =
    LANE_W'(INSTR_BYTES - 1);

  assign w_hs      = r_instr_valid && instr_ready;
  assign w_aligned = (redirect_pc[1:0] == 2'b00);
  assign w_pc_inc  = r_pc + 32'(INSTR_BYTES);
  assign w_last    = r_rsp_pend && (r_rsp_lane == LAST_LANE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  // next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FETCH: if (r_lane == LAST_LANE) w_state_nxt = DRAIN;
      DRAIN: if (w_last) w_state_nxt = HOLD;
      HOLD:  if (instr_ready) w_state_nxt = FETCH;
      FAULT: w_state_nxt = FAULT;
      default: w_state_nxt = FETCH;
    endcase
    if (redirect_valid)
      w_state_nxt = w_aligned ? FETCH : FAULT;
  end

  // request issue: the handshake edge already issues
  // lane 0 of the next word to keep 6-cycle throughput
  always_comb begin
    w_issue      = 1'b0;
    w_issue_addr = r_mem_addr;
    w_issue_lane = '0;
    unique case (r_state)
      FETCH: begin
        w_issue      = 1'b1;
        w_issue_addr = r_pc[ADDR_W-1:0] + ADDR_W'(r_lane);
        w_issue_lane = r_lane;
      end
      HOLD: if (w_hs) begin
        w_issue      = 1'b1;
        w_issue_addr = w_pc_inc[ADDR_W-1:0];
      end
      default: ;
    endcase
    if (redirect_valid) w_issue = 1'b0;
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_lane        <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_req_lane    <= '0;
      r_rsp_pend    <= 1'b0;
      r_rsp_lane    <= '0;
      for (int i = 0; i < INSTR_BYTES - 1; i++)
        r_buf[i] <= 8'h00;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_fault       <= 1'b0;
    end else if (redirect_valid) begin
      r_mem_req     <= 1'b0;
      r_rsp_pend    <= 1'b0;
      r_lane        <= '0;
      r_instr_valid <= 1'b0;
      if (w_aligned) r_pc    <= redirect_pc;
      else           r_fault <= 1'b1;
    end else begin
      r_mem_req  <= w_issue;
      r_req_lane <= w_issue_lane;
      if (w_issue) r_mem_addr <= w_issue_addr;
      r_rsp_pend <= r_mem_req;
      r_rsp_lane <= r_req_lane;
      if (r_rsp_pend && !w_last)
        r_buf[r_rsp_lane] <= mem_rdata;
      if (r_state == FETCH)
        r_lane <= r_lane + 1'b1;
      if (r_state == DRAIN && w_last) begin
        r_instr       <= {mem_rdata, r_buf[2],
                          r_buf[1], r_buf[0]};
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
      end
      if (r_state == HOLD && w_hs) begin
        r_instr_valid <= 1'b0;
        r_pc          <= w_pc_inc;
        r_lane        <= LANE_W'(1);
      end
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte-wide
// synchronous memory model returning data one cycle after a request.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // junk on unrequested cycles exposes any unguarded capture
  always @(posedge clk)
    mem_rdata <= mem_req ? mem[mem_addr] : 8'($urandom);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 30) begin
      step();
      n++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a]   = w[7:0];
    mem[a+1] = w[15:8];
    mem[a+2] = w[23:16];
    mem[a+3] = w[31:24];
  endtask

  logic [31:0] held;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    put_word(32'h0,    32'h00100513);
    put_word(32'h4,    32'h00200593);
    put_word(32'h40,   32'h00300613);
    put_word(32'h80,   32'h00400693);
    put_word(32'hFFFC, 32'h12345678);

    rst_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step(); step();

    // reset state
    chk("rst_req",   32'(mem_req),     32'd0);
    chk("rst_addr",  32'(mem_addr),    32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr,            32'd0);
    chk("rst_pc",    instr_pc,         32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);

    // first fetch: requests on cycles 1..4, valid on 6
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("f0_req%0d", k),  32'(mem_req),  32'd1);
      chk($sformatf("f0_addr%0d", k), 32'(mem_addr), 32'(k - 1));
    end
    step();
    chk("f0_req5",   32'(mem_req),     32'd0);
    chk("f0_valid5", 32'(instr_valid), 32'd0);
    step();
    chk("f0_valid6", 32'(instr_valid), 32'd1);
    chk("f0_instr",  instr,            32'h00100513);
    chk("f0_pc",     instr_pc,         32'h0);
    step();
    chk("f1_req",   32'(mem_req),     32'd1);
    chk("f1_addr",  32'(mem_addr),    32'h4);
    chk("f1_valid", 32'(instr_valid), 32'd0);

    // backpressure in HOLD
    instr_ready = 1'b0;
    wait_valid("bp_wait");
    chk("bp_instr", instr,    32'h00200593);
    chk("bp_pc",    instr_pc, 32'h4);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_valid", 32'(instr_valid), 32'd1);
      chk("bp_hold_instr", instr,            32'h00200593);
      chk("bp_hold_req",   32'(mem_req),     32'd0);
    end
    instr_ready = 1'b1;
    step();
    chk("bp_next_req",   32'(mem_req),     32'd1);
    chk("bp_next_addr",  32'(mem_addr),    32'h8);
    chk("bp_next_valid", 32'(instr_valid), 32'd0);

    // reset mid-fetch clears state immediately
    rst_n = 1'b0;
    #1;
    chk("arst_req",  32'(mem_req),  32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rs_addr0", 32'(mem_addr), 32'h0);
    step();
    step();
    chk("rs_addr2", 32'(mem_addr), 32'h2);

    // redirect during lane 2
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("rd_req",   32'(mem_req),     32'd0);
    chk("rd_valid", 32'(instr_valid), 32'd0);
    wait_valid("rd_wait");
    chk("rd_pc",    instr_pc, 32'h40);
    chk("rd_instr", instr,    32'h00300613);

    // redirect coinciding with handshake
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    wait_valid("rh_wait0");
    chk("rh_pc0", instr_pc, 32'h0);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    chk("rh_valid", 32'(instr_valid), 32'd0);
    wait_valid("rh_wait1");
    chk("rh_pc1",   instr_pc, 32'h80);
    chk("rh_instr", instr,    32'h00400693);

    // misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("mf_fault", 32'(fetch_fault), 32'd1);
    chk("mf_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("mf_noreq", 32'(mem_req), 32'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    wait_valid("mf_wait");
    chk("mf_pc",     instr_pc,         32'h80);
    chk("mf_sticky", 32'(fetch_fault), 32'd1);

    // address wrap at top of 16-bit space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFC;
    step();
    redirect_valid = 1'b0;
    chk("wr_req0", 32'(mem_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wr_addr", 32'(mem_addr), 32'hFFFC + 32'(k));
    end
    wait_valid("wr_wait0");
    chk("wr_pc0",    instr_pc, 32'hFFFC);
    chk("wr_instr0", instr,    32'h12345678);
    held = instr;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("wr_req1",  32'(mem_req),  32'd1);
    chk("wr_addr1", 32'(mem_addr), 32'h0);
    wait_valid("wr_wait1");
    chk("wr_pc1",    instr_pc, 32'h00010000);
    chk("wr_instr1", instr,    32'h00100513);
    chk("wr_changed", 32'(instr != held), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
